// File: rtl/byte_lane_data_memory.sv
// Byte-addressed data memory with byte lane strobes, sign/zero-extending loads,
// misalignment detection and a two-cycle bit-band set/clear read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_i & ready_o.
// ready_o depends only on the FSM state. Each accepted request produces exactly
// one single-cycle rvalid_o pulse, in acceptance order. err_o and rdata_o are
// meaningful only while rvalid_o is high.
module byte_lane_data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BB_ENABLE  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  output logic                          ready_o,
  input  logic                          we_i,
  input  logic [1:0]                    size_i,
  input  logic                          unsigned_i,
  input  logic                          bb_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] bb_bit_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic                          rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          dbg_state_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IW    = ADDR_WIDTH - OFF;
  localparam int DEPTH = 1 << IW;
  localparam int BW    = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IW-1:0]         bb_idx_q, bb_idx_d;
  logic [BW-1:0]         bb_bit_q, bb_bit_d;
  logic                  bb_val_q, bb_val_d;
  logic [DATA_WIDTH-1:0] bb_old_q, bb_old_d;

  // One byte-wide bank per lane; contents are deliberately not reset.
  logic [7:0] bank_q [LANES][DEPTH];

  logic [IW-1:0]         idx;
  logic [OFF-1:0]        off;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] wshift;
  logic [LANES-1:0]      strb;
  logic [DATA_WIDTH-1:0] bb_new;
  logic [2:0]            amask;
  logic                  misaligned, size_illegal, bb_illegal, illegal;
  logic [LANES-1:0]      mem_we;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign idx         = addr_i[ADDR_WIDTH-1:OFF];
  assign off         = addr_i[OFF-1:0];
  assign ready_o     = (state_q == IDLE);
  assign accept      = req_i & ready_o;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

  // Gather the addressed word from all banks.
  always_comb begin
    rd_word = '0;
    for (int l = 0; l < LANES; l++) rd_word[l*8 +: 8] = bank_q[l][idx];
  end

  // Legality: access size must divide the address; double only exists at 64 bits.
  always_comb begin
    amask        = (3'd1 << size_i) - 3'd1;
    misaligned   = |(addr_i[2:0] & amask);
    size_illegal = (size_i == 2'd3) && (DATA_WIDTH == 32);
    bb_illegal   = (BB_ENABLE == 0) || (off != '0);
    illegal      = bb_i ? bb_illegal : (size_illegal || misaligned);
  end

  // Load path: shift addressed bytes down to bit 0, then zero/sign extend.
  always_comb begin
    logic sign;
    int   nbits;
    shifted = rd_word >> {off, 3'b000};
    nbits   = 8 << size_i;
    case (size_i)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DATA_WIDTH-1];
    endcase
    if (unsigned_i) sign = 1'b0;
    ld_data = '0;
    for (int b = 0; b < DATA_WIDTH; b++) ld_data[b] = (b < nbits) ? shifted[b] : sign;
  end

  // Store path: move right-aligned data to the addressed lanes and build strobes.
  always_comb begin
    wshift = wdata_i << {off, 3'b000};
    strb   = '0;
    for (int l = 0; l < LANES; l++)
      strb[l] = (l >= int'(off)) && (l < int'(off) + (1 << size_i));
  end

  // Bit-band result: latched pre-modification word with one bit replaced.
  always_comb begin
    bb_new           = bb_old_q;
    bb_new[bb_bit_q] = bb_val_q;
  end

  // Memory write port: RMW write-back has priority, otherwise a legal store.
  always_comb begin
    mem_we    = '0;
    mem_idx   = idx;
    mem_wdata = wshift;
    if (state_q == RMW_WR) begin
      mem_we    = '1;
      mem_idx   = bb_idx_q;
      mem_wdata = bb_new;
    end else if (accept && !illegal && !bb_i && we_i) begin
      mem_we = strb;
    end
    if (!rst_ni) mem_we = '0;
  end

  // Byte-lane write into the banks.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < LANES; l++)
      if (mem_we[l]) bank_q[l][mem_idx] <= mem_wdata[l*8 +: 8];
  end

  // FSM next state and registered response.
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    bb_idx_d = bb_idx_q;
    bb_bit_d = bb_bit_q;
    bb_val_d = bb_val_q;
    bb_old_d = bb_old_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end else if (bb_i) begin
            state_d  = RMW_WR;
            bb_idx_d = idx;
            bb_bit_d = bb_bit_i;
            bb_val_d = wdata_i[0];
            bb_old_d = rd_word;
          end else begin
            rvalid_d = 1'b1;
            if (!we_i) rdata_d = ld_data;
          end
        end
      end
      RMW_WR: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = bb_old_q;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      bb_idx_q <= '0;
      bb_bit_q <= '0;
      bb_val_q <= 1'b0;
      bb_old_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      bb_idx_q <= bb_idx_d;
      bb_bit_q <= bb_bit_d;
      bb_val_q <= bb_val_d;
      bb_old_q <= bb_old_d;
    end
  end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Bench for byte_lane_data_memory (32-bit, bit-band enabled): byte-level memory
// model, per-cycle output compare, and directed vectors with literal results.
module tb_byte_lane_data_memory;

  logic        clk, rst_n;
  logic        req, ready, we, uns, bb, rvalid, err, dbg_state;
  logic [1:0]  size;
  logic [4:0]  bb_bit;
  logic [9:0]  addr;
  logic [31:0] wdata, rdata;

  byte_lane_data_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BB_ENABLE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_o(ready), .we_i(we),
    .size_i(size), .unsigned_i(uns), .bb_i(bb), .bb_bit_i(bb_bit),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [7:0]  mem_m [1024];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = '0;
  logic        rmw_m = 1'b0;
  logic [9:0]  rmw_addr;
  logic [4:0]  rmw_bit;
  logic        rmw_val;
  logic [31:0] rmw_old;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [9:0] a, input logic [1:0] sz, input logic u);
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v |= 32'(mem_m[int'(a) + i]) << (8 * i);
    if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic bit m_illegal(input logic is_bb, input logic [1:0] sz, input logic [9:0] a);
    if (is_bb) return (a % 4) != 0;
    if (sz == 2'd3) return 1'b1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  // Model: decide acceptance and predict each response at the rising edge.
  always @(posedge clk) begin
    rsp_t        r;
    logic [31:0] nw;
    cyc++;
    if (!rst_n) begin
      rmw_m      = 1'b0;
      exp_q.delete();
      last_rdata = '0;
    end else if (rmw_m) begin
      nw          = rmw_old;
      nw[rmw_bit] = rmw_val;
      for (int i = 0; i < 4; i++) mem_m[int'(rmw_addr) + i] = nw[8*i +: 8];
      rmw_m = 1'b0;
    end else if (req) begin
      acc_cnt++;
      if (m_illegal(bb, size, addr)) begin
        last_rdata = '0;
        r = '{cyc, 1'b1, 32'h0};
      end else if (bb) begin
        rmw_m      = 1'b1;
        rmw_addr   = addr;
        rmw_bit    = bb_bit;
        rmw_val    = wdata[0];
        rmw_old    = m_load(addr, 2'd2, 1'b1);
        last_rdata = rmw_old;
        r = '{cyc + 1, 1'b0, rmw_old};
      end else if (we) begin
        for (int i = 0; i < (1 << size); i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
        r = '{cyc, 1'b0, last_rdata};
      end else begin
        last_rdata = m_load(addr, size, uns);
        r = '{cyc, 1'b0, last_rdata};
      end
      exp_q.push_back(r);
    end
  end

  // Compare: every falling edge, check handshake and response outputs.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end else begin
      chk("ready", 32'(ready), 32'(!rmw_m));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        chk("rsp_rvalid", 32'(rvalid), 32'd1);
        chk("rsp_err", 32'(err), 32'(r.err));
        chk("rsp_rdata", rdata, r.data);
      end else begin
        chk("idle_rvalid", 32'(rvalid), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic b,
                       input logic [4:0] bit_i, input logic [9:0] a, input logic [31:0] wd);
    int start;
    int n;
    start  = acc_cnt;
    n      = 0;
    req    = 1'b1;
    we     = w;
    size   = sz;
    uns    = u;
    bb     = b;
    bb_bit = bit_i;
    addr   = a;
    wdata  = wd;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acc_cnt == start && n < 20);
    if (acc_cnt == start) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
    issue(1'b1, sz, 1'b0, 1'b0, 5'd0, a, wd);
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [9:0] a);
    issue(1'b0, sz, u, 1'b0, 5'd0, a, 32'h0);
  endtask

  task automatic bitband(input logic [4:0] bit_i, input logic v, input logic [9:0] a);
    issue(1'b0, 2'd0, 1'b0, 1'b1, bit_i, a, {31'h0, v});
  endtask

  task automatic check_lit(input string name, input logic e, input logic [31:0] d);
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({name, "_err"}, 32'(err), 32'(e));
    chk({name, "_rdata"}, rdata, d);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    bb = 1'b0; bb_bit = 5'd0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Word store, then signed/unsigned byte loads of the top byte.
    store(2'd2, 10'h010, 32'hA1B2C3D4);  check_lit("st_word", 1'b0, 32'h0);
    load(2'd0, 1'b0, 10'h013);           check_lit("ldb_s", 1'b0, 32'hFFFFFFA1);
    load(2'd0, 1'b1, 10'h013);           check_lit("ldb_u", 1'b0, 32'h000000A1);
    load(2'd1, 1'b0, 10'h012);           check_lit("ldh_s", 1'b0, 32'hFFFFA1B2);
    load(2'd0, 1'b0, 10'h010);           check_lit("ldb_lo", 1'b0, 32'hFFFFFFD4);

    // Half store into upper lanes of an existing word.
    store(2'd2, 10'h010, 32'h11223344);
    store(2'd1, 10'h012, 32'h5555BEEF);  check_lit("st_half", 1'b0, 32'hFFFFFFD4);
    load(2'd2, 1'b0, 10'h010);           check_lit("half_merge", 1'b0, 32'hBEEF3344);

    // Byte store into lane 1, then half loads around it.
    store(2'd2, 10'h014, 32'h55667788);
    store(2'd0, 10'h015, 32'hFFFFFF7E);
    load(2'd1, 1'b0, 10'h014);           check_lit("ldh_pos", 1'b0, 32'h00007E88);
    load(2'd1, 1'b0, 10'h016);           check_lit("ldh_hi", 1'b0, 32'h00005566);
    load(2'd0, 1'b0, 10'h014);           check_lit("ldb_neg", 1'b0, 32'hFFFFFF88);

    // Illegal requests: error, zero data, memory unchanged.
    load(2'd1, 1'b0, 10'h011);           check_lit("mis_half", 1'b1, 32'h0);
    load(2'd2, 1'b0, 10'h012);           check_lit("mis_word", 1'b1, 32'h0);
    load(2'd3, 1'b0, 10'h010);           check_lit("size3", 1'b1, 32'h0);
    store(2'd2, 10'h016, 32'hFFFFFFFF);  check_lit("mis_store", 1'b1, 32'h0);
    store(2'd3, 10'h010, 32'hFFFFFFFF);  check_lit("size3_store", 1'b1, 32'h0);
    load(2'd2, 1'b0, 10'h010);           check_lit("unchanged_10", 1'b0, 32'hBEEF3344);
    load(2'd2, 1'b0, 10'h014);           check_lit("unchanged_14", 1'b0, 32'h55667E88);

    // Bit-band set then clear.
    store(2'd2, 10'h020, 32'h0000F0F0);
    bitband(5'd3, 1'b1, 10'h020);
    chk("bb_ready_low", 32'(ready), 32'd0);
    chk("bb_no_early_rsp", 32'(rvalid), 32'd0);
    @(negedge clk);
    check_lit("bb_set", 1'b0, 32'h0000F0F0);
    chk("bb_ready_back", 32'(ready), 32'd1);
    load(2'd2, 1'b0, 10'h020);           check_lit("bb_set_rd", 1'b0, 32'h0000F0F8);
    bitband(5'd15, 1'b0, 10'h020);
    @(negedge clk);
    check_lit("bb_clr", 1'b0, 32'h0000F0F8);
    load(2'd2, 1'b0, 10'h020);           check_lit("bb_clr_rd", 1'b0, 32'h000070F8);
    bitband(5'd0, 1'b1, 10'h022);        check_lit("bb_mis", 1'b1, 32'h0);

    // Bit-band followed by a held load to the same word.
    bitband(5'd0, 1'b1, 10'h020);
    load(2'd2, 1'b0, 10'h020);           check_lit("bb_then_ld", 1'b0, 32'h000070F9);

    // Back-to-back store then load.
    store(2'd2, 10'h030, 32'hDEADBEEF);
    load(2'd2, 1'b0, 10'h030);           check_lit("b2b", 1'b0, 32'hDEADBEEF);

    // Reset during the RMW write cycle aborts the write.
    bitband(5'd31, 1'b1, 10'h020);
    #2 rst_n = 1'b0;
    #1;
    chk("rmw_rst_rvalid", 32'(rvalid), 32'd0);
    chk("rmw_rst_err", 32'(err), 32'd0);
    chk("rmw_rst_rdata", rdata, 32'd0);
    chk("rmw_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    load(2'd2, 1'b0, 10'h020);           check_lit("rmw_aborted", 1'b0, 32'h000070F9);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
